wb_commit_seq: RTL and testbench

Write-back commit sequencer for the Y86 datapath. It accepts one retired-instruction record per handshake from the memory stage, buffers records in a small FIFO, and drives the register file's single write port. Records carrying two destinations (popq) are serialised over two cycles, E result first, then M result. It also tracks halt and counts retired instructions for the testbench.

---
 rtl/wb_commit_seq.sv | 120 ++++++++++++
 tb/tb_wb_commit_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_seq.sv
// wb_commit_seq: buffers retired-instruction records and serialises their register-file writes
module wb_commit_seq #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       icode_i,
  input  logic [3:0]       dstE_i,
  input  logic [3:0]       dstM_i,
  input  logic [63:0]      valE_i,
  input  logic [63:0]      valM_i,
  output logic             we_o,
  output logic [3:0]       waddr_o,
  output logic [63:0]      wdata_o,
  output logic             retire_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retire_cnt_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vale;
    logic [63:0] valm;
  } rec_t;

  typedef enum logic {PH_E, PH_M} phase_e;

  rec_t             mem_q [DEPTH];
  rec_t             head;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             halt_seen_q, halt_seen_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, empty, is_halt, e_wr, m_wr;

  assign head        = mem_q[rd_q];
  assign empty       = (count_q == '0);
  assign is_halt     = (head.icode == IHALT);
  assign e_wr        = (head.dste != RNONE) && !is_halt;
  assign m_wr        = (head.dstm != RNONE) && !is_halt;
  assign ready_o     = (count_q < CW'(DEPTH)) && !halt_seen_q;
  assign push        = valid_i && ready_o;
  assign rd_d        = pop ? rd_q + 1'b1 : rd_q;
  assign wr_d        = push ? wr_q + 1'b1 : wr_q;
  assign count_d     = count_q + CW'(push) - CW'(pop);
  assign halt_seen_d = halt_seen_q | (push && icode_i == IHALT);
  assign halted_d    = halted_q | (pop && is_halt);
  assign cnt_d       = pop ? cnt_q + CNT_W'(1) : cnt_q;
  assign retire_o    = pop;
  assign halted_o    = halted_q;
  assign retire_cnt_o = cnt_q;

  // Phase FSM: pick which destination of the head record is written this cycle and when it pops
  always_comb begin
    phase_d = phase_q;
    pop     = 1'b0;
    we_o    = 1'b0;
    waddr_o = RNONE;
    wdata_o = '0;
    if (!empty) begin
      if (phase_q == PH_M) begin
        we_o    = 1'b1;
        waddr_o = head.dstm;
        wdata_o = head.valm;
        pop     = 1'b1;
        phase_d = PH_E;
      end else if (e_wr) begin
        we_o    = 1'b1;
        waddr_o = head.dste;
        wdata_o = head.vale;
        if (m_wr) phase_d = PH_M;
        else      pop     = 1'b1;
      end else if (m_wr) begin
        we_o    = 1'b1;
        waddr_o = head.dstm;
        wdata_o = head.valm;
        pop     = 1'b1;
      end else begin
        pop = 1'b1;
      end
    end
  end

  // Control state: pointers, occupancy, phase, halt tracking and retire counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      phase_q     <= PH_E;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  // Record storage: payload needs no reset since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= '{icode_i, dstE_i, dstM_i, valE_i, valM_i};
  end
endmodule

// File: tb/tb_wb_commit_seq.sv
// tb_wb_commit_seq: directed self-checking bench for the write-back commit sequencer
module tb_wb_commit_seq;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  icode_i = 4'h1;
  logic [3:0]  dstE_i = 4'hF;
  logic [3:0]  dstM_i = 4'hF;
  logic [63:0] valE_i = '0;
  logic [63:0] valM_i = '0;
  logic        we_o;
  logic [3:0]  waddr_o;
  logic [63:0] wdata_o;
  logic        retire_o;
  logic        halted_o;
  logic [31:0] retire_cnt_o;

  int n_tests = 0;
  int n_fail = 0;
  logic [67:0] wlog [$];
  logic [63:0] rf [16];

  wb_commit_seq #(.DEPTH(2), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .icode_i(icode_i), .dstE_i(dstE_i), .dstM_i(dstM_i), .valE_i(valE_i), .valM_i(valM_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .retire_o(retire_o),
    .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference register file and ordered write log, fed by what the DUT commits at each edge
  always @(posedge clk_i) begin
    if (rst_n_i && we_o) begin
      wlog.push_back({waddr_o, wdata_o});
      rf[waddr_o] = wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_rec(input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
    icode_i = ic;
    dstE_i  = de;
    dstM_i  = dm;
    valE_i  = ve;
    valM_i  = vm;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm,
                      input logic [63:0] ve, input logic [63:0] vm);
    set_rec(ic, de, dm, ve, vm);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    wlog.delete();
  endtask

  initial begin
    int budget;
    #1;
    chk("rst_we", we_o, 0);
    chk("rst_waddr", waddr_o, 4'hF);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_retire", retire_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_cnt", retire_cnt_o, 0);
    #11;
    rst_n_i = 1'b1;

    // Reset while a dual-write record sits in PH_M with another queued behind it
    set_rec(4'hB, 4'h5, 4'h6, 64'h50, 64'h60);
    valid_i = 1'b1;
    step();
    set_rec(4'hB, 4'h7, 4'h8, 64'h70, 64'h80);
    step();
    valid_i = 1'b0;
    chk("mid_ready_full", ready_o, 0);
    chk("mid_phm_waddr", waddr_o, 4'h6);
    chk("mid_cnt_pre", retire_cnt_o, 0);
    rst_n_i = 1'b0;
    #1;
    wlog.delete();
    chk("mid_rst_we", we_o, 0);
    chk("mid_rst_waddr", waddr_o, 4'hF);
    chk("mid_rst_wdata", wdata_o, 0);
    chk("mid_rst_cnt", retire_cnt_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("mid_post_ready", ready_o, 1);
    repeat (3) step();
    chk("mid_post_we", we_o, 0);
    chk("mid_no_stale", 68'(wlog.size()), 0);

    // Single-write IOPQ
    send(4'h6, 4'h3, 4'hF, 64'h2A, 64'h0);
    chk("opq_we", we_o, 1);
    chk("opq_waddr", waddr_o, 4'h3);
    chk("opq_wdata", wdata_o, 64'h2A);
    chk("opq_retire", retire_o, 1);
    step();
    chk("opq_retire_done", retire_o, 0);
    chk("opq_we_done", we_o, 0);
    chk("opq_cnt", retire_cnt_o, 1);

    // Dual-write IPOPQ: E first, then M, retire only on the second cycle
    send(4'hB, 4'h4, 4'h2, 64'h108, 64'hDEAD);
    chk("pop_e_we", we_o, 1);
    chk("pop_e_waddr", waddr_o, 4'h4);
    chk("pop_e_wdata", wdata_o, 64'h108);
    chk("pop_e_retire", retire_o, 0);
    step();
    chk("pop_m_we", we_o, 1);
    chk("pop_m_waddr", waddr_o, 4'h2);
    chk("pop_m_wdata", wdata_o, 64'hDEAD);
    chk("pop_m_retire", retire_o, 1);
    step();
    chk("pop_cnt", retire_cnt_o, 2);
    chk("pop_rf2", rf[2], 64'hDEAD);

    // popq %rsp: same destination twice, M value must win
    send(4'hB, 4'h4, 4'h4, 64'h108, 64'h55);
    chk("rsp_e", {waddr_o, wdata_o}, {4'h4, 64'h108});
    step();
    chk("rsp_m", {waddr_o, wdata_o}, {4'h4, 64'h55});
    step();
    chk("rsp_rf4", rf[4], 64'h55);
    chk("rsp_cnt", retire_cnt_o, 3);

    // M-only record writes in PH_E and retires in one cycle
    send(4'h5, 4'hF, 4'h9, 64'h0, 64'h77);
    chk("monly_w", {we_o, waddr_o, wdata_o}, {1'b1, 4'h9, 64'h77});
    chk("monly_retire", retire_o, 1);
    step();
    chk("monly_cnt", retire_cnt_o, 4);

    // Back-pressure: four IPOPQ records offered with valid held high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_rec(4'hB, 4'(i), 4'(i + 8), 64'h100 + 64'(i), 64'h200 + 64'(i));
      valid_i = 1'b1;
      #1;
      budget = 0;
      while (!ready_o && budget < 20) begin
        step();
        budget++;
      end
      chk("bp_wait_bound", 68'(budget < 20), 1);
      step();
      if (i == 1) chk("bp_ready_drop", ready_o, 0);
    end
    valid_i = 1'b0;
    repeat (12) step();
    chk("bp_nwrites", 68'(wlog.size()), 8);
    for (int i = 0; i < 4; i++) begin
      if (wlog.size() >= 2 * i + 2) begin
        chk("bp_wr_e", wlog[2*i], {4'(i), 64'h100 + 64'(i)});
        chk("bp_wr_m", wlog[2*i+1], {4'(i + 8), 64'h200 + 64'(i)});
      end
    end
    chk("bp_cnt", retire_cnt_o, 4);
    chk("bp_ready_end", ready_o, 1);

    // INOP then IHALT, then an IOPQ that must never be accepted
    do_reset();
    send(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    chk("nop_we", we_o, 0);
    chk("nop_retire", retire_o, 1);
    send(4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    chk("halt_ready", ready_o, 0);
    chk("halt_we", we_o, 0);
    chk("halt_retire", retire_o, 1);
    chk("halt_not_yet", halted_o, 0);
    set_rec(4'h6, 4'h3, 4'hF, 64'h99, 64'h0);
    valid_i = 1'b1;
    step();
    chk("halt_sticky", halted_o, 1);
    chk("halt_cnt1", retire_cnt_o, 2);
    repeat (6) step();
    valid_i = 1'b0;
    chk("halt_ready_hold", ready_o, 0);
    chk("halt_no_write", 68'(wlog.size()), 0);
    chk("halt_cnt2", retire_cnt_o, 2);
    chk("halt_still", halted_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
